// File: rtl/asrm_alu_seq.sv
// ---------------------------------------------------------------------------
// asrm_alu_seq
// Multi-cycle ALU for the asrm core. Add/sub/logic/compares finish in one
// execute cycle; shifts iterate shift_step bits per cycle; multiply is
// shift-add and divide/modulo is restoring, one bit per cycle.
//
// Ports:
//   clk              - system clock
//   reset            - asynchronous, active-low reset
//   in_valid         - operation request
//   in_ready         - high in IDLE; op accepted on in_valid & in_ready
//   working_register - operand A
//   other_register   - operand B
//   status_register  - current SR, latched at accept
//   opperand         - opcode
//   done             - one-cycle pulse, result outputs valid
//   out              - result value
//   out_reg          - destination register id (0 = WR, sr_id for compares)
//   status_out       - updated status register
//   busy             - not IDLE
// ---------------------------------------------------------------------------
module asrm_alu_seq #(
    parameter int         wordsize   = 16,
    parameter logic [3:0] sr_id      = 4'd2,
    parameter int         shift_step = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [wordsize-1:0] working_register,
    input  logic [wordsize-1:0] other_register,
    input  logic [wordsize-1:0] status_register,
    input  logic [3:0]          opperand,
    output logic                done,
    output logic [wordsize-1:0] out,
    output logic [3:0]          out_reg,
    output logic [wordsize-1:0] status_out,
    output logic                busy
);

    localparam int           W       = wordsize;
    localparam int           CW      = $clog2(wordsize) + 1;
    localparam logic [W-1:0] WordLen = W'(W);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StRun  = 2'd2,
        StDone = 2'd3
    } state_t;

    typedef enum logic [3:0] {
        OpAdd = 4'd0,
        OpSub = 4'd1,
        OpAnd = 4'd2,
        OpOr  = 4'd3,
        OpXor = 4'd4,
        OpNot = 4'd5,
        OpLsl = 4'd6,
        OpLsr = 4'd7,
        OpEq  = 4'd8,
        OpLes = 4'd9,
        OpMul = 4'd10,
        OpDiv = 4'd11,
        OpMod = 4'd12,
        OpAsr = 4'd13
    } op_t;

    state_t        state_q, state_d;

    logic [W-1:0]  a_q, b_q, sr_q;
    logic [3:0]    op_q;

    // work_q: shift value / multiplicand / quotient
    // aux_q : multiplier
    // acc_q : product accumulator / partial remainder
    logic [W-1:0]  work_q, work_d;
    logic [W-1:0]  aux_q, aux_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          k_q, k_d;

    logic [W-1:0]  out_q, status_q;
    logic [3:0]    outReg_q;

    logic          accept;
    logic          isShift;
    logic          isLong;
    logic          finishing;
    logic [CW-1:0] shiftN;
    logic [CW-1:0] stepAmt;

    logic [W-1:0]  shiftNext;
    logic          shiftOut;
    logic [W:0]    remShift;
    logic          divFits;
    logic [W-1:0]  divRem;

    logic [W-1:0]  aluRes;
    logic          kFlag, vFlag, cmpBit;
    logic [W-1:0]  resOut, resSr;
    logic [3:0]    resReg;

    assign accept    = in_valid && (state_q == StIdle);
    assign isShift   = (op_q == OpLsl) || (op_q == OpLsr) || (op_q == OpAsr);
    assign isLong    = (op_q == OpMul) || (op_q == OpDiv) || (op_q == OpMod);
    assign shiftN    = CW'(b_q % WordLen);
    // A 2-bit step only while at least two bits remain, so odd amounts are exact.
    assign stepAmt   = (isShift && (shift_step == 2) && (cnt_q >= CW'(2))) ? CW'(2) : CW'(1);
    assign finishing = ((state_q == StExec) || (state_q == StRun)) && (state_d == StDone);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Zero-length shifts skip RUN entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (isLong || (isShift && (shiftN != '0))) begin
                    state_d = StRun;
                end else begin
                    state_d = StDone;
                end
            end
            StRun: begin
                if (cnt_q == stepAmt) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Handshake and status outputs, decoded from the state.
    always_comb begin
        in_ready = (state_q == StIdle);
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
    end

    // Operand, opcode and SR capture at accept; later input changes are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q  <= '0;
            b_q  <= '0;
            sr_q <= '0;
            op_q <= '0;
        end else if (accept) begin
            a_q  <= working_register;
            b_q  <= other_register;
            sr_q <= status_register;
            op_q <= opperand;
        end
    end

    // One shift step; the carry is the last bit to leave the word.
    always_comb begin
        shiftNext = work_q;
        shiftOut  = 1'b0;
        if (stepAmt == CW'(2)) begin
            case (op_q)
                OpLsl: begin
                    shiftNext = {work_q[W-3:0], 2'b00};
                    shiftOut  = work_q[W-2];
                end
                OpLsr: begin
                    shiftNext = {2'b00, work_q[W-1:2]};
                    shiftOut  = work_q[1];
                end
                OpAsr: begin
                    shiftNext = {{2{work_q[W-1]}}, work_q[W-1:2]};
                    shiftOut  = work_q[1];
                end
                default: begin
                end
            endcase
        end else begin
            case (op_q)
                OpLsl: begin
                    shiftNext = {work_q[W-2:0], 1'b0};
                    shiftOut  = work_q[W-1];
                end
                OpLsr: begin
                    shiftNext = {1'b0, work_q[W-1:1]};
                    shiftOut  = work_q[0];
                end
                OpAsr: begin
                    shiftNext = {work_q[W-1], work_q[W-1:1]};
                    shiftOut  = work_q[0];
                end
                default: begin
                end
            endcase
        end
    end

    // One restoring-division step. With a zero divisor every trial fits,
    // so the quotient fills with ones and A shifts through into the remainder.
    always_comb begin
        remShift = {acc_q, work_q[W-1]};
        divFits  = (remShift >= {1'b0, b_q});
        divRem   = divFits ? W'(remShift - {1'b0, b_q}) : remShift[W-1:0];
    end

    // Iterative datapath: EXEC loads the working registers, RUN steps them.
    always_comb begin
        work_d = work_q;
        aux_d  = aux_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        k_d    = k_q;
        case (state_q)
            StExec: begin
                work_d = a_q;
                aux_d  = b_q;
                acc_d  = '0;
                k_d    = 1'b0;
                cnt_d  = isShift ? shiftN : CW'(W);
            end
            StRun: begin
                cnt_d = cnt_q - stepAmt;
                if (isShift) begin
                    work_d = shiftNext;
                    k_d    = shiftOut;
                end else if (op_q == OpMul) begin
                    acc_d  = aux_q[0] ? (acc_q + work_q) : acc_q;
                    work_d = work_q << 1;
                    aux_d  = aux_q >> 1;
                end else begin
                    acc_d  = divRem;
                    work_d = {work_q[W-2:0], divFits};
                end
            end
            default: begin
            end
        endcase
    end

    // Iterative datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            work_q <= '0;
            aux_q  <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            k_q    <= 1'b0;
        end else begin
            work_q <= work_d;
            aux_q  <= aux_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            k_q    <= k_d;
        end
    end

    // Raw result and K/V flags. Iterative ops read the post-step values so
    // the result is ready in the same cycle the last step completes.
    always_comb begin
        aluRes = '0;
        kFlag  = 1'b0;
        vFlag  = 1'b0;
        cmpBit = 1'b0;
        case (op_q)
            OpAdd: begin
                {kFlag, aluRes} = {1'b0, a_q} + {1'b0, b_q};
                vFlag = (a_q[W-1] == b_q[W-1]) && (aluRes[W-1] != a_q[W-1]);
            end
            OpSub: begin
                {kFlag, aluRes} = {1'b0, a_q} - {1'b0, b_q};
                vFlag = (a_q[W-1] != b_q[W-1]) && (aluRes[W-1] != a_q[W-1]);
            end
            OpAnd: aluRes = a_q & b_q;
            OpOr:  aluRes = a_q | b_q;
            OpXor: aluRes = a_q ^ b_q;
            OpNot: aluRes = ~b_q;
            OpEq:  cmpBit = (a_q == b_q);
            OpLes: cmpBit = (a_q < b_q);
            OpLsl, OpLsr, OpAsr: begin
                aluRes = work_d;
                kFlag  = k_d;
            end
            OpMul: aluRes = acc_d;
            OpDiv: begin
                aluRes = work_d;
                vFlag  = (b_q == '0);
            end
            OpMod: begin
                aluRes = acc_d;
                vFlag  = (b_q == '0);
            end
            default: begin
            end
        endcase
    end

    // Final out / out_reg / SR: compares write only C and target the SR,
    // illegal opcodes return zero and pass the SR through untouched.
    always_comb begin
        resOut = aluRes;
        resReg = 4'd0;
        resSr  = {sr_q[W-1:4], vFlag, kFlag, (aluRes == '0), sr_q[0]};
        if (op_q >= 4'd14) begin
            resOut = '0;
            resSr  = sr_q;
        end else if ((op_q == OpEq) || (op_q == OpLes)) begin
            resSr  = {sr_q[W-1:1], cmpBit};
            resOut = resSr;
            resReg = sr_id;
        end
    end

    // Result registers hold between completions.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q    <= '0;
            outReg_q <= '0;
            status_q <= '0;
        end else if (finishing) begin
            out_q    <= resOut;
            outReg_q <= resReg;
            status_q <= resSr;
        end
    end

    assign out        = out_q;
    assign out_reg    = outReg_q;
    assign status_out = status_q;

endmodule
